// File: rtl/nv_ram_rwsp_rd_ctrl.sv
// rtl/nv_ram_rwsp_rd_ctrl.sv - burst read controller for a two-stage registered RAM
module nv_ram_rwsp_rd_ctrl #(
  parameter int DEPTH = 245,
  parameter int WIDTH = 514,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [AW-1:0]    req_len,
  output logic [AW-1:0]    rd_ra,
  output logic             rd_re,
  output logic             rd_ore,
  input  logic [WIDTH-1:0] rd_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             req_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Remaining count needs one extra bit: a full-depth burst holds DEPTH itself.
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [AW:0]   rem_q;
  logic          s1_v, s1_last, s2_v, s2_last, err_q;
  logic          accept, addr_ok, issue_last, beat_done;
  logic [AW:0]   len_ext, burst_cnt;

  assign accept     = req_valid & req_ready;
  assign addr_ok    = ({1'b0, req_addr} < DEPTH_C);
  assign len_ext    = {1'b0, req_len};
  assign burst_cnt  = (len_ext >= DEPTH_C - 1'b1) ? DEPTH_C : len_ext + 1'b1;
  assign issue_last = (rem_q == (AW+1)'(1));
  assign beat_done  = out_valid & out_ready & out_last;

  assign out_valid = s2_v;
  assign out_data  = rd_dout;
  assign out_last  = s2_v & s2_last;
  assign rd_ra     = addr_q;
  assign req_err   = err_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: RUN while issuing, DRAIN until the last beat leaves
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && addr_ok)     state_nxt = RUN;
      RUN:     if (rd_re && issue_last)   state_nxt = DRAIN;
      DRAIN:   if (beat_done)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Outputs: output register advances when s2 is free or draining; address stage refills behind it
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rd_ore    = s1_v & (~s2_v | out_ready);
    rd_re     = (state == RUN) & (~s1_v | rd_ore);
  end

  // Address/count registers, error pulse and the two pipeline stage flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      err_q <= accept & ~addr_ok;
      if (accept && addr_ok) begin
        addr_q <= req_addr;
        rem_q  <= burst_cnt;
      end else if (rd_re) begin
        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (rd_re) begin
        s1_v    <= 1'b1;
        s1_last <= issue_last;
      end else if (rd_ore) begin
        s1_v    <= 1'b0;
      end
      if (rd_ore) begin
        s2_v    <= 1'b1;
        s2_last <= s1_last;
      end else if (out_ready) begin
        s2_v    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_rd_ctrl.sv
// tb/tb_nv_ram_rwsp_rd_ctrl.sv - self-checking bench for nv_ram_rwsp_rd_ctrl
module tb_nv_ram_rwsp_rd_ctrl;

  localparam int DEPTH = 245;
  localparam int WIDTH = 514;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [AW-1:0]    req_len;
  logic [AW-1:0]    rd_ra;
  logic             rd_re;
  logic             rd_ore;
  logic [WIDTH-1:0] rd_dout = '0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             req_err;
  logic             busy;

  nv_ram_rwsp_rd_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_ra(rd_ra), .rd_re(rd_re), .rd_ore(rd_ore), .rd_dout(rd_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .req_err(req_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Distinct, address-derived contents so order/duplication errors are visible
  function automatic logic [WIDTH-1:0] mem_word(input int a);
    logic [WIDTH-1:0] w;
    logic [7:0]       a8;
    a8 = 8'(a);
    w  = '0;
    for (int i = 0; i < 16; i++)
      w[i*32 +: 32] = {a8 ^ 8'(i), 24'(a8) * 24'd7 + 24'(i)};
    w[WIDTH-1 -: 2] = 2'b10;
    return w;
  endfunction

  // RAM: address register on rd_re, output register on rd_ore
  logic [AW-1:0] ram_ra_q = '0;
  always @(posedge clk) begin
    if (rd_re)  ram_ra_q <= rd_ra;
    if (rd_ore) rd_dout  <= mem_word(int'(ram_ra_q));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: queues of expected issue addresses and expected beats
  typedef struct { int addr; bit last; } beat_t;
  int    iq[$];
  beat_t dq[$];
  int    issued_log[$];
  int    outst   = 0;
  int    beats   = 0;
  bit    active  = 0;
  bit    err_pend = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rd_re",     64'(rd_re),     64'd0);
      chk("rst_rd_ore",    64'(rd_ore),    64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      chk("rst_req_err",   64'(req_err),   64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_rd_ra",     64'(rd_ra),     64'd0);
      iq.delete();
      dq.delete();
      outst = 0; active = 0; err_pend = 0;
    end else begin
      chk("req_ready", 64'(req_ready), 64'(!active));
      chk("busy",      64'(busy),      64'(active));
      chk("req_err",   64'(req_err),   64'(err_pend));
      err_pend = 0;
      if (rd_re) begin
        if (iq.size() == 0) chk("rd_re_unexpected", 64'd1, 64'd0);
        else begin
          chk("rd_ra", 64'(rd_ra), 64'(iq[0]));
          void'(iq.pop_front());
          issued_log.push_back(int'(rd_ra));
          outst++;
        end
      end
      if (out_valid) begin
        if (dq.size() == 0) chk("out_valid_unexpected", 64'd1, 64'd0);
        else begin
          chk_data("out_data", out_data, mem_word(dq[0].addr));
          chk("out_last", 64'(out_last), 64'(dq[0].last));
          if (out_ready) begin
            beats++;
            if (dq[0].last) active = 0;
            void'(dq.pop_front());
            outst--;
          end
        end
      end
      chk("outstanding_le_2", 64'(outst <= 2), 64'd1);
      if (req_valid && req_ready) begin
        if (int'(req_addr) >= DEPTH) err_pend = 1;
        else begin
          int    n;
          beat_t b;
          n = ((int'(req_len) < DEPTH - 1) ? int'(req_len) : DEPTH - 1) + 1;
          for (int i = 0; i < n; i++) begin
            b.addr = (int'(req_addr) + i) % DEPTH;
            b.last = (i == n - 1);
            iq.push_back(b.addr);
            dq.push_back(b);
          end
          active = 1;
        end
      end
    end
  end

  // Presents a request for exactly one cycle T; returns 1ns into cycle T+1
  task automatic do_req(input int a, input int l);
    req_addr  = AW'(a);
    req_len   = AW'(l);
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_at_T", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (req_ready && dq.size() == 0) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk({nm, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run_basic(input string nm);
    out_ready = 1'b1;
    do_req(10, 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("%s_rd_re_k%0d", nm, k), 64'(rd_re), 64'(k <= 4));
      if (k <= 4) chk($sformatf("%s_rd_ra_k%0d", nm, k), 64'(rd_ra), 64'(9 + k));
      chk($sformatf("%s_out_valid_k%0d", nm, k), 64'(out_valid), 64'(k >= 3 && k <= 6));
      chk($sformatf("%s_out_last_k%0d", nm, k), 64'(out_last), 64'(k == 6));
      chk($sformatf("%s_req_ready_k%0d", nm, k), 64'(req_ready), 64'(k >= 7));
      @(posedge clk); #1;
    end
  endtask

  logic [WIDTH-1:0] hold;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    run_basic("s1");

    issued_log.delete(); beats = 0;
    do_req(243, 3);
    wait_idle("s2");
    chk("s2_issues", 64'(issued_log.size()), 64'd4);
    if (issued_log.size() == 4) begin
      chk("s2_ra0", 64'(issued_log[0]), 64'd243);
      chk("s2_ra1", 64'(issued_log[1]), 64'd244);
      chk("s2_ra2", 64'(issued_log[2]), 64'd0);
      chk("s2_ra3", 64'(issued_log[3]), 64'd1);
    end
    chk("s2_beats", 64'(beats), 64'd4);

    beats = 0;
    do_req(0, 4);
    for (int k = 1; k <= 10; k++) begin
      out_ready = !(k >= 4 && k <= 6);
      @(negedge clk);
      if (k == 4) hold = out_data;
      if (k >= 4 && k <= 6) begin
        chk($sformatf("s3_stall_rd_re_k%0d", k), 64'(rd_re), 64'd0);
        chk($sformatf("s3_stall_valid_k%0d", k), 64'(out_valid), 64'd1);
        chk_data($sformatf("s3_stall_data_k%0d", k), out_data, mem_word(1));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("s3");
    chk("s3_beats", 64'(beats), 64'd5);

    do_req(245, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("s4_req_err_k%0d", k), 64'(req_err), 64'(k == 1));
      chk($sformatf("s4_rd_re_k%0d", k), 64'(rd_re), 64'd0);
      chk($sformatf("s4_req_ready_k%0d", k), 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end

    issued_log.delete(); beats = 0;
    do_req(100, 250);
    wait_idle("s5");
    chk("s5_beats", 64'(beats), 64'd245);
    chk("s5_issues", 64'(issued_log.size()), 64'd245);
    if (issued_log.size() == 245) begin
      chk("s5_ra144", 64'(issued_log[144]), 64'd244);
      chk("s5_ra145", 64'(issued_log[145]), 64'd0);
      chk("s5_ra244", 64'(issued_log[244]), 64'd99);
    end

    beats = 0;
    do_req(20, 7);
    for (int k = 1; k <= 4; k++) begin @(negedge clk); @(posedge clk); #1; end
    chk("s6_beats_before_reset", 64'(beats), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("s6_async_out_valid", 64'(out_valid), 64'd0);
    chk("s6_async_rd_re",     64'(rd_re),     64'd0);
    chk("s6_async_rd_ore",    64'(rd_ore),    64'd0);
    chk("s6_async_busy",      64'(busy),      64'd0);
    chk("s6_async_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("s6_quiet_valid_k%0d", k), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_basic("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_rd_ctrl.md
NV_RAM_RWSP_RD_CTRL -- requirements
Module: nv_ram_rwsp_rd_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 245, meaning number of RAM entries (valid addresses 0..DEPTH-1).
REQ-002 SHALL have parameter WIDTH, default 514, meaning RAM data width.
REQ-003 SHALL have parameter AW, default 8, meaning address and length field width.
REQ-004 SHALL have ports:
  clk            input   1      single clock; all state on posedge
  reset          input   1      asynchronous, active-high reset
  req_valid      input   1      burst request valid
  req_ready      output  1      controller can accept a request
  req_addr       input   AW     first RAM address of burst
  req_len        input   AW     beats minus one
  rd_ra          output  AW     RAM read address
  rd_re          output  1      RAM read-address capture enable
  rd_ore         output  1      RAM output-register capture enable
  rd_dout        input   WIDTH  RAM registered read data
  out_valid      output  1      output beat valid
  out_ready      input   1      downstream accepts beat
  out_data       output  WIDTH  output beat data
  out_last       output  1      final beat of burst
  req_err        output  1      one-cycle pulse: request rejected
  busy           output  1      burst in progress (state != IDLE)
REQ-005 Clock port SHALL be clk; reset SHALL be asynchronous, active-high, named reset.

Function
REQ-006 SHALL drive a RAM with two-stage read: rd_re captures rd_ra into the address register; rd_ore captures the addressed word onto rd_dout; each stage holds when its enable is low.
REQ-007 States SHALL be IDLE, RUN, DRAIN; req_ready = 1 only in IDLE.
REQ-008 Handshake req_valid&req_ready with req_addr <= DEPTH-1 SHALL load addr counter = req_addr, remaining count = min(req_len, DEPTH-1)+1, and enter RUN next cycle.
REQ-009 Handshake with req_addr >= DEPTH SHALL pulse req_err for exactly one cycle (the next cycle), issue no reads, and remain IDLE.
REQ-010 Stage flags: s1_v (address register holds pending read), s2_v (rd_dout holds a beat); out_valid = s2_v; out_data = rd_dout, combinationally.
REQ-011 rd_ore = s1_v & (!s2_v | out_ready).
REQ-012 rd_re = (state == RUN) & (!s1_v | rd_ore); rd_ra = addr counter; rd_ra is meaningful only when rd_re = 1.
REQ-013 On each rd_re: addr counter increments, wrapping DEPTH-1 -> 0; remaining count decrements; on the issue where remaining = 1, state RUN -> DRAIN.
REQ-014 Last flag SHALL travel with each read through s1 and s2; out_last = s2_v & last flag of s2.
REQ-015 DRAIN -> IDLE when out_valid & out_ready & out_last; req_ready = 1 the following cycle.
REQ-016 Latency: request accepted cycle T -> first rd_re at T+1, first rd_ore at T+2, first out_valid at T+3.
REQ-017 With out_ready held 1, throughput SHALL be one beat per cycle, no bubbles.
REQ-018 With out_ready = 0 and s2_v = 1, out_data SHALL be held stable; no beat lost, duplicated, or reordered.
REQ-019 Issued-but-undelivered reads SHALL never exceed 2.
REQ-020 req_valid outside IDLE SHALL be ignored.

Reset
REQ-021 During reset: state IDLE, s1_v = s2_v = 0, counters 0; outputs req_ready = 1, rd_re = 0, rd_ore = 0, out_valid = 0, out_last = 0, req_err = 0, busy = 0, rd_ra = 0.
REQ-022 Reset mid-burst SHALL abandon the burst immediately; no beat after reset release until a new request is accepted.

Verification
REQ-023 Scenario: addr=10, len=3, out_ready=1, accepted T -> rd_re T+1..T+4 with rd_ra 10,11,12,13; out_valid T+3..T+6; out_last only at T+6; req_ready=1 at T+7.
REQ-024 Scenario: addr=243, len=3 -> rd_ra 243,244,0,1; 4 beats, last on 4th.
REQ-025 Scenario: addr=0, len=4, out_ready dropped 3 cycles after first out_valid -> out_data stable while stalled; rd_re stops once s1_v = s2_v = 1; 5 beats in order, no duplicates.
REQ-026 Scenario: addr=245 -> req_err=1 for one cycle at T+1; rd_re never asserted; req_ready=1 at T+1.
REQ-027 Scenario: len=250 -> exactly 245 beats, rd_ra wraps once, out_last on beat 245.
REQ-028 Scenario: reset asserted in RUN after 2 beats -> out_valid, rd_re, rd_ore, busy go 0 asynchronously; req_ready=1; next request behaves as in REQ-023.
